weight_update_sequencer: RTL and testbench

WEIGHT_UPDATE_SEQUENCER -- requirements
Module: weight_update_sequencer

---
 rtl/weight_update_sequencer_if.sv | 28 ++
 rtl/weight_update_sequencer.sv | 79 +++++++
 tb/tb_weight_update_sequencer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/weight_update_sequencer_if.sv
// weight_update_sequencer_if: gradient handshake, storage update and read-grant bus
interface weight_update_sequencer_if #(
  parameter int data_size = 16,
  parameter int size = 3
);
  logic start;
  logic [31:0] num_layers;
  logic grad_valid;
  logic [data_size*size-1:0] grad_data;
  logic grad_ready;
  logic [31:0] layer_index;
  logic [31:0] row_index;
  logic [data_size*size-1:0] dc_dw;
  logic is_update;
  logic rd_req;
  logic is_read;
  logic busy;
  logic done;
  logic error;
  modport master (
    output start, num_layers, grad_valid, grad_data, rd_req,
    input grad_ready, layer_index, row_index, dc_dw, is_update, is_read, busy, done, error
  );
  modport slave (
    input start, num_layers, grad_valid, grad_data, rd_req,
    output grad_ready, layer_index, row_index, dc_dw, is_update, is_read, busy, done, error
  );
endinterface

// File: rtl/weight_update_sequencer.sv
// weight_update_sequencer: sweeps storage rows last layer to first, writing one gradient row per update
module weight_update_sequencer #(
  parameter int data_size = 16,
  parameter int size = 3,
  parameter int layer_size = 5
) (
  input logic clk,
  input logic reset,
  weight_update_sequencer_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] UPDATE = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  logic [1:0] state_q, state_d;
  logic [31:0] layer_q, layer_d, row_q, row_d;
  logic [data_size*size-1:0] dc_q, dc_d;
  logic err_q, err_d;
  // next state: accept start in IDLE, capture a row in FETCH, advance row/layer after each UPDATE
  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    row_d = row_q;
    dc_d = dc_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (bus.start) begin
        if (bus.num_layers > 32'(layer_size)) begin
          err_d = 1'b1;
        end else begin
          err_d = 1'b0;
          row_d = '0;
          layer_d = bus.num_layers == '0 ? layer_q : bus.num_layers - 32'd1;
          state_d = bus.num_layers == '0 ? DONE : FETCH;
        end
      end
      FETCH: if (bus.grad_valid) begin
        dc_d = bus.grad_data;
        state_d = UPDATE;
      end
      UPDATE: if (row_q < 32'(size - 1)) begin
        row_d = row_q + 32'd1;
        state_d = FETCH;
      end else if (layer_q != '0) begin
        row_d = '0;
        layer_d = layer_q - 32'd1;
        state_d = FETCH;
      end else begin
        state_d = DONE;
      end
      DONE: state_d = IDLE;
    endcase
  end
  // state and datapath registers, cleared immediately on reset so an aborted sweep issues no further update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      layer_q <= '0;
      row_q <= '0;
      dc_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      row_q <= row_d;
      dc_q <= dc_d;
      err_q <= err_d;
    end
  end
  assign bus.grad_ready = state_q == FETCH;
  assign bus.is_update = state_q == UPDATE;
  assign bus.busy = state_q != IDLE;
  assign bus.done = state_q == DONE;
  assign bus.is_read = bus.rd_req && state_q == IDLE;
  assign bus.error = err_q;
  assign bus.layer_index = layer_q;
  assign bus.row_index = row_q;
  assign bus.dc_dw = dc_q;
endmodule

// File: tb/tb_weight_update_sequencer.sv
// tb_weight_update_sequencer: directed sweeps with a scoreboard of expected storage updates
module tb_weight_update_sequencer;
  localparam int DS = 16;
  localparam int SZ = 3;
  localparam int LS = 5;
  localparam int W = DS * SZ;
  typedef struct {
    int l;
    int r;
    logic [W-1:0] d;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  int upd = 0;
  int stall_bad = 0;
  exp_t q[$];
  exp_t m;
  weight_update_sequencer_if #(.data_size(DS), .size(SZ)) bus ();
  weight_update_sequencer #(.data_size(DS), .size(SZ), .layer_size(LS)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  // storage samples on the falling edge, so the scoreboard does too
  always @(negedge clk) begin
    if (bus.is_update === 1'b1) begin
      upd++;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL upd_unexpected got layer=%0d row=%0d data=%h, none expected",
                 bus.layer_index, bus.row_index, bus.dc_dw);
      end else begin
        m = q.pop_front();
        if ({bus.layer_index, bus.row_index, bus.dc_dw, bus.is_read} !== {32'(m.l), 32'(m.r), m.d, 1'b0}) begin
          bad++;
          $display("FAIL upd_order got layer=%0d row=%0d data=%h rd=%b, want layer=%0d row=%0d data=%h rd=0",
                   bus.layer_index, bus.row_index, bus.dc_dw, bus.is_read, m.l, m.r, m.d);
        end
      end
    end
  end
  task automatic drive_sweep(input int n, input int stall_k, input int stall_len, input int abort_at, output int cyc);
    int k;
    int stalled;
    bit presented;
    bit xfer;
    bit stall_now;
    logic [W-1:0] row;
    exp_t e;
    k = 0;
    stalled = 0;
    presented = 0;
    row = '0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.num_layers = n;
    @(posedge clk);
    #1 bus.start = 1'b0;
    bus.num_layers = 32'd7;
    cyc = 2;
    forever begin
      if (bus.done === 1'b1) break;
      if (cyc > 400) begin
        cyc = -1;
        break;
      end
      if (k < n * SZ) begin
        if (!presented) begin
          row = {16'(k + 1), 16'($urandom), 16'(n * 16 + k)};
          e.l = n - 1 - k / SZ;
          e.r = k % SZ;
          e.d = row;
          q.push_back(e);
          presented = 1;
        end
        stall_now = (k == stall_k) && bus.grad_ready === 1'b1 && stalled < stall_len;
        if (stall_now) begin
          stalled++;
          if (bus.is_update !== 1'b0) stall_bad++;
        end
        bus.grad_valid = !stall_now;
        bus.grad_data = row;
      end else begin
        bus.grad_valid = 1'b0;
      end
      xfer = bus.grad_valid && bus.grad_ready;
      @(posedge clk);
      #1 cyc++;
      if (xfer) begin
        k++;
        presented = 0;
      end
      if (abort_at != 0 && k == abort_at && bus.is_update === 1'b1) begin
        reset = 1'b1;
        cyc = -2;
        break;
      end
    end
  endtask
  task automatic test_reset();
    #12;
    total++;
    if ({bus.grad_ready, bus.is_update, bus.is_read, bus.busy, bus.done, bus.error,
         bus.layer_index, bus.row_index, bus.dc_dw} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got rdy=%b upd=%b rd=%b busy=%b done=%b err=%b l=%0d r=%0d d=%h, want all 0",
               bus.grad_ready, bus.is_update, bus.is_read, bus.busy, bus.done, bus.error,
               bus.layer_index, bus.row_index, bus.dc_dw);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic test_basic();
    int c;
    int u0;
    u0 = upd;
    drive_sweep(2, -1, 0, 0, c);
    total++;
    if (c !== 14) begin bad++; $display("FAIL basic_cycles got %0d want 14", c); end
    total++;
    if ({bus.layer_index, bus.row_index, bus.busy} !== {32'd0, 32'd2, 1'b1}) begin
      bad++;
      $display("FAIL basic_final got l=%0d r=%0d busy=%b want l=0 r=2 busy=1", bus.layer_index, bus.row_index, bus.busy);
    end
    @(posedge clk);
    #1;
    total++;
    if ({bus.done, bus.busy} !== 2'b00) begin bad++; $display("FAIL basic_idle got done=%b busy=%b want 0 0", bus.done, bus.busy); end
    total++;
    if (upd - u0 !== 6) begin bad++; $display("FAIL basic_updates got %0d want 6", upd - u0); end
    total++;
    if (q.size() !== 0) begin bad++; $display("FAIL basic_leftover got %0d want 0", q.size()); end
  endtask
  task automatic test_stall();
    int c;
    int u0;
    u0 = upd;
    stall_bad = 0;
    drive_sweep(2, 1, 4, 0, c);
    total++;
    if (c !== 18) begin bad++; $display("FAIL stall_cycles got %0d want 18", c); end
    total++;
    if (stall_bad !== 0) begin bad++; $display("FAIL stall_update got %0d want 0", stall_bad); end
    @(posedge clk);
    #1;
    total++;
    if (upd - u0 !== 6) begin bad++; $display("FAIL stall_updates got %0d want 6", upd - u0); end
  endtask
  task automatic test_error();
    int c;
    int u0;
    bit seen_done;
    u0 = upd;
    seen_done = 0;
    bus.grad_valid = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.num_layers = 6;
    @(posedge clk);
    #1 bus.start = 1'b0;
    total++;
    if ({bus.error, bus.busy} !== 2'b10) begin bad++; $display("FAIL err_flag got err=%b busy=%b want 1 0", bus.error, bus.busy); end
    repeat (6) begin
      @(posedge clk);
      #1 if (bus.done === 1'b1 || bus.busy === 1'b1) seen_done = 1;
    end
    total++;
    if ({seen_done, bus.error} !== 2'b01) begin bad++; $display("FAIL err_idle got done_or_busy=%b err=%b want 0 1", seen_done, bus.error); end
    total++;
    if (upd - u0 !== 0) begin bad++; $display("FAIL err_updates got %0d want 0", upd - u0); end
    drive_sweep(1, -1, 0, 0, c);
    total++;
    if (c !== 8) begin bad++; $display("FAIL err_recover_cycles got %0d want 8", c); end
    total++;
    if (bus.error !== 1'b0) begin bad++; $display("FAIL err_clear got %b want 0", bus.error); end
    @(posedge clk);
    #1;
    total++;
    if (upd - u0 !== 3) begin bad++; $display("FAIL err_recover_updates got %0d want 3", upd - u0); end
  endtask
  task automatic test_zero();
    int u0;
    u0 = upd;
    bus.rd_req = 1'b1;
    #1;
    total++;
    if (bus.is_read !== 1'b1) begin bad++; $display("FAIL zero_read_idle got %b want 1", bus.is_read); end
    @(negedge clk);
    bus.start = 1'b1;
    bus.num_layers = 0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    total++;
    if ({bus.done, bus.busy, bus.is_read, bus.error} !== 4'b1100) begin
      bad++;
      $display("FAIL zero_done got done=%b busy=%b rd=%b err=%b want 1 1 0 0", bus.done, bus.busy, bus.is_read, bus.error);
    end
    @(posedge clk);
    #1;
    total++;
    if ({bus.done, bus.busy, bus.is_read} !== 3'b001) begin
      bad++;
      $display("FAIL zero_idle got done=%b busy=%b rd=%b want 0 0 1", bus.done, bus.busy, bus.is_read);
    end
    total++;
    if (upd - u0 !== 0) begin bad++; $display("FAIL zero_updates got %0d want 0", upd - u0); end
    bus.rd_req = 1'b0;
  endtask
  task automatic test_reset_mid();
    int c;
    int u0;
    u0 = upd;
    drive_sweep(2, -1, 0, 2, c);
    #1;
    total++;
    if (c !== -2) begin bad++; $display("FAIL mid_abort_point got %0d want -2", c); end
    total++;
    if ({bus.grad_ready, bus.is_update, bus.is_read, bus.busy, bus.done, bus.error,
         bus.layer_index, bus.row_index, bus.dc_dw} !== '0) begin
      bad++;
      $display("FAIL mid_reset_outputs got rdy=%b upd=%b busy=%b done=%b l=%0d r=%0d d=%h, want all 0",
               bus.grad_ready, bus.is_update, bus.busy, bus.done, bus.layer_index, bus.row_index, bus.dc_dw);
    end
    bus.grad_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (upd - u0 !== 1) begin bad++; $display("FAIL mid_updates got %0d want 1", upd - u0); end
    total++;
    if (q.size() !== 1) begin bad++; $display("FAIL mid_pending got %0d want 1", q.size()); end
    q.delete();
    u0 = upd;
    drive_sweep(2, -1, 0, 0, c);
    total++;
    if (c !== 14) begin bad++; $display("FAIL mid_restart_cycles got %0d want 14", c); end
    @(posedge clk);
    #1;
    total++;
    if (upd - u0 !== 6 || q.size() !== 0) begin
      bad++;
      $display("FAIL mid_restart_updates got %0d left=%0d want 6 left=0", upd - u0, q.size());
    end
  endtask
  initial begin
    bus.start = 1'b0;
    bus.num_layers = '0;
    bus.grad_valid = 1'b0;
    bus.grad_data = '0;
    bus.rd_req = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_error();
    test_zero();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
